// File: rtl/bird_column.sv
// bird_column: one LED column of a flappy-bird style game.
//
// A free-running divider produces a gravity/blink tick. The bird flies
// upward by FLAP_H rows on each new press of KEY0 and falls one row per
// tick. It crashes when it falls off the bottom or overlaps a pipe row.
// From DEAD, a press returns it to IDLE at START_ROW.
//
// Optional feature: define BIRD_CRASH_BLINK_EN to blink the bird once per
// tick while DEAD. With the macro undefined, no blink logic is built.
//
// Ports:
//   clock      rising-edge clock
//   reset_n    asynchronous active-low reset
//   KEY0       flap button, active-high, synchronous to clock
//   pipe_mask  [ROWS-1:0] rows occupied by a pipe in this column
//   bird_row   [ROWS-1:0] registered one-hot LED drive (0 while blinked off)
//   bird_pos   [clog2(ROWS)-1:0] current bird row index
//   crashed    high while DEAD
//   tick       one-cycle pulse when the divider wraps
module bird_column #(
    parameter int ROWS      = 8,
    parameter int TICK_DIV  = 1792,
    parameter int FLAP_H    = 2,
    parameter int START_ROW = ROWS / 2
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic                    KEY0,
    input  logic [ROWS-1:0]         pipe_mask,
    output logic [ROWS-1:0]         bird_row,
    output logic [$clog2(ROWS)-1:0] bird_pos,
    output logic                    crashed,
    output logic                    tick
);

    localparam int PW = $clog2(ROWS);
    // One extra bit so that pos + FLAP_H cannot wrap before saturation.
    localparam int AW = PW + 1;
    localparam int CW = $clog2(TICK_DIV);

    localparam logic [AW-1:0]   TOP     = AW'(ROWS - 1);
    localparam logic [AW-1:0]   FLAP    = AW'(FLAP_H);
    localparam logic [PW-1:0]   START   = PW'(START_ROW);
    localparam logic [CW-1:0]   CNT_MAX = CW'(TICK_DIV - 1);
    localparam logic [ROWS-1:0] ONE     = ROWS'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_FLY  = 2'd1,
        S_DEAD = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   pos_q,   pos_d;
    logic [CW-1:0]   cnt_q,   cnt_d;
    logic            key_q,   key_d;
    logic [ROWS-1:0] row_q,   row_d;

    logic            tick_w;
    logic            flap;
    logic            hit;
    logic [AW-1:0]   pos_up;
    logic [PW-1:0]   pos_sat;

    // Divider, edge detect and the saturated flap target.
    always_comb begin
        tick_w  = (cnt_q == CNT_MAX);
        cnt_d   = tick_w ? '0 : cnt_q + 1'b1;
        key_d   = KEY0;
        flap    = KEY0 & ~key_q;
        hit     = |((ONE << pos_q) & pipe_mask);
        pos_up  = {1'b0, pos_q} + FLAP;
        pos_sat = (pos_up > TOP) ? TOP[PW-1:0] : pos_up[PW-1:0];
    end

    // Next state / position. Within FLY: collision > flap > gravity.
    always_comb begin
        state_d = state_q;
        pos_d   = pos_q;
        unique case (state_q)
            S_IDLE: begin
                if (flap) begin
                    state_d = S_FLY;
                    pos_d   = pos_sat;
                end
            end
            S_FLY: begin
                if (hit) begin
                    state_d = S_DEAD;
                end else if (flap) begin
                    pos_d = pos_sat;
                end else if (tick_w) begin
                    // Falling below row 0 is a crash; pos stays at 0.
                    if (pos_q == '0) state_d = S_DEAD;
                    else             pos_d   = pos_q - 1'b1;
                end
            end
            S_DEAD: begin
                if (flap) begin
                    state_d = S_IDLE;
                    pos_d   = START;
                end
            end
            default: begin
                state_d = S_IDLE;
                pos_d   = START;
            end
        endcase
    end

`ifdef BIRD_CRASH_BLINK_EN
    logic blink_q, blink_d;

    // Phase toggles per tick only while staying in DEAD; any other
    // cycle (including the one leaving DEAD) forces the on phase.
    always_comb begin
        blink_d = 1'b1;
        if (state_q == S_DEAD && !flap)
            blink_d = tick_w ? ~blink_q : blink_q;
        row_d = blink_d ? (ONE << pos_d) : '0;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) blink_q <= 1'b1;
        else          blink_q <= blink_d;
    end
`else
    always_comb begin
        row_d = ONE << pos_d;
    end
`endif

    // key_q resets high so a key held through reset release is not a flap.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            pos_q   <= START;
            cnt_q   <= '0;
            key_q   <= 1'b1;
            row_q   <= ONE << START;
        end else begin
            state_q <= state_d;
            pos_q   <= pos_d;
            cnt_q   <= cnt_d;
            key_q   <= key_d;
            row_q   <= row_d;
        end
    end

    assign bird_row = row_q;
    assign bird_pos = pos_q;
    assign crashed  = (state_q == S_DEAD);
    assign tick     = tick_w;

endmodule

// File: tb/tb_bird_column.sv
`timescale 1ns/1ps
module tb_bird_column;

    localparam int ROWS      = 8;
    localparam int TICK_DIV  = 4;
    localparam int FLAP_H    = 2;
    localparam int START_ROW = 4;

    logic            clock = 1'b0;
    logic            reset_n = 1'b0;
    logic            KEY0 = 1'b0;
    logic [ROWS-1:0] pipe_mask = '0;
    logic [ROWS-1:0] bird_row;
    logic [2:0]      bird_pos;
    logic            crashed;
    logic            tick;

    int n_chk = 0;
    int n_err = 0;
    bit started = 1'b0;

    bird_column #(
        .ROWS(ROWS), .TICK_DIV(TICK_DIV), .FLAP_H(FLAP_H), .START_ROW(START_ROW)
    ) dut (
        .clock(clock), .reset_n(reset_n), .KEY0(KEY0), .pipe_mask(pipe_mask),
        .bird_row(bird_row), .bird_pos(bird_pos), .crashed(crashed), .tick(tick)
    );

    always #5 clock = ~clock;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // mode: 0 idle, 1 flying, 2 dead. cyc counts clock edges since reset,
    // so the divider value is simply cyc mod TICK_DIV.
    int m_mode = 0, m_pos = START_ROW, m_cyc = 0;
    bit m_prev = 1'b1, m_blink = 1'b1;
    int n_mode, n_pos;
    bit n_blink, m_flap, m_tick;

    always_comb begin
        n_mode  = m_mode;
        n_pos   = m_pos;
        n_blink = 1'b1;
        m_flap  = KEY0 && !m_prev;
        m_tick  = (m_cyc % TICK_DIV) == TICK_DIV - 1;
        if (m_mode == 0) begin
            if (m_flap) begin
                n_mode = 1;
                n_pos  = (m_pos + FLAP_H > ROWS - 1) ? ROWS - 1 : m_pos + FLAP_H;
            end
        end else if (m_mode == 1) begin
            if (pipe_mask[m_pos]) n_mode = 2;
            else if (m_flap) n_pos = (m_pos + FLAP_H > ROWS - 1) ? ROWS - 1 : m_pos + FLAP_H;
            else if (m_tick) begin
                if (m_pos == 0) n_mode = 2;
                else            n_pos  = m_pos - 1;
            end
        end else begin
            if (m_flap) begin
                n_mode = 0;
                n_pos  = START_ROW;
            end else begin
`ifdef BIRD_CRASH_BLINK_EN
                n_blink = m_tick ? !m_blink : m_blink;
`else
                n_blink = 1'b1;
`endif
            end
        end
    end

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            m_mode <= 0; m_pos <= START_ROW; m_cyc <= 0; m_prev <= 1'b1; m_blink <= 1'b1;
        end else begin
            m_mode <= n_mode; m_pos <= n_pos; m_cyc <= m_cyc + 1;
            m_prev <= KEY0;   m_blink <= n_blink;
        end
    end

    // Compare every cycle, away from the rising edge.
    always @(negedge clock) begin
        if (started && reset_n) begin
            chk("model_pos",     32'(bird_pos), 32'(m_pos));
            chk("model_crashed", 32'(crashed),  32'(m_mode == 2));
            chk("model_tick",    32'(tick),     32'(m_tick));
            chk("model_row",     32'(bird_row), m_blink ? (32'd1 << m_pos) : 32'd0);
        end
    end

    // ---------------- stimulus ----------------
    task automatic clk(input int n);
        repeat (n) @(posedge clock);
        #2;
    endtask

    // Mid-cycle reset pulse; outputs must take reset values without an edge.
    task automatic do_reset();
        reset_n = 1'b0;
        #0.5;
        chk("rst_pos",     32'(bird_pos), 32'd4);
        chk("rst_row",     32'(bird_row), 32'h10);
        chk("rst_crashed", 32'(crashed),  32'd0);
        chk("rst_tick",    32'(tick),     32'd0);
        #0.5;
        reset_n = 1'b1;
        started = 1'b1;
    endtask

    initial begin
        int nt;
        clk(1);
        do_reset();

        // Idle for 20 cycles: position held, 5 tick pulses.
        nt = 0;
        for (int i = 0; i < 20; i++) begin
            clk(1);
            if (tick) nt++;
        end
        chk("idle_ticks", 32'(nt), 32'd5);
        chk("idle_pos",   32'(bird_pos), 32'd4);
        chk("idle_row",   32'(bird_row), 32'h10);

        // Press and hold, fall, coincident flap/tick, saturation, fall to DEAD.
        clk(1); do_reset();
        clk(1); KEY0 = 1'b1;
        clk(1); chk("flap_pos", 32'(bird_pos), 32'd6); chk("flap_row", 32'(bird_row), 32'h40);
        clk(10); chk("hold_pos", 32'(bird_pos), 32'd3);
        KEY0 = 1'b0; clk(1);
        KEY0 = 1'b1; clk(1); chk("press2_pos", 32'(bird_pos), 32'd5);
        KEY0 = 1'b0; clk(1);
        KEY0 = 1'b1; clk(1); chk("flap_on_tick_pos", 32'(bird_pos), 32'd7);
        KEY0 = 1'b0; clk(1);
        KEY0 = 1'b1; clk(1); chk("sat_pos", 32'(bird_pos), 32'd7); chk("sat_crashed", 32'(crashed), 32'd0);
        KEY0 = 1'b0;
        clk(29); chk("bottom_pos", 32'(bird_pos), 32'd0); chk("bottom_crashed", 32'(crashed), 32'd0);
        clk(1);  chk("fall_dead", 32'(crashed), 32'd1); chk("fall_pos", 32'(bird_pos), 32'd0);
        chk("dead_row0", 32'(bird_row), 32'h01);
        clk(4);
`ifdef BIRD_CRASH_BLINK_EN
        chk("blink_off", 32'(bird_row), 32'h00);
`else
        chk("no_blink", 32'(bird_row), 32'h01);
`endif
        clk(4); chk("blink_on", 32'(bird_row), 32'h01);
        KEY0 = 1'b1; clk(1);
        chk("restart_pos", 32'(bird_pos), 32'd4); chk("restart_crashed", 32'(crashed), 32'd0);
        KEY0 = 1'b0;

        // Pipe collision at row 3.
        clk(1); do_reset();
        clk(1); KEY0 = 1'b1;
        clk(1); KEY0 = 1'b0;
        clk(10); chk("pre_hit_pos", 32'(bird_pos), 32'd3);
        pipe_mask = 8'h08;
        clk(1); chk("hit_crashed", 32'(crashed), 32'd1); chk("hit_pos", 32'(bird_pos), 32'd3);
        clk(2); chk("hit_frozen", 32'(bird_pos), 32'd3);
        KEY0 = 1'b1; clk(1);
        chk("hit_restart_pos", 32'(bird_pos), 32'd4); chk("hit_restart_crashed", 32'(crashed), 32'd0);
        KEY0 = 1'b0; pipe_mask = '0;

        // Reset in DEAD with KEY0 held; key must be released before a flap.
        clk(1); do_reset();
        clk(1); KEY0 = 1'b1; pipe_mask = 8'h40;
        clk(1); chk("c_flap_pos", 32'(bird_pos), 32'd6);
        clk(1); chk("c_dead", 32'(crashed), 32'd1);
        clk(2);
        do_reset();
        pipe_mask = '0;
        clk(3); chk("held_idle_pos", 32'(bird_pos), 32'd4); chk("held_idle_crashed", 32'(crashed), 32'd0);
        KEY0 = 1'b0; clk(1);
        KEY0 = 1'b1; clk(1); chk("repress_pos", 32'(bird_pos), 32'd6);
        KEY0 = 1'b0;

        // Randomized run against the model, with occasional mid-cycle resets.
        for (int i = 0; i < 3000; i++) begin
            clk(1);
            KEY0      = ($urandom % 3) == 0;
            pipe_mask = (($urandom % 6) == 0) ? (8'h01 << ($urandom % 8)) : 8'h00;
            if (($urandom % 400) == 0) do_reset();
        end

        clk(2);
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
